// File: rtl/cla_seq_pkg.sv
// Shared constants and state encoding for the sequential wide adder built on the 8-bit CLA slice.
package cla_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/carry_lookahead_adder_8bit.sv
// Combinational 8-bit carry-lookahead adder slice: {cout,sum} = a + b + cin.
module carry_lookahead_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] gen_s;
  logic [7:0] prop_s;
  logic [8:0] carry_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Carry recurrence c[i+1] = g[i] | p[i]&c[i], evaluated in a local vector.
  always_comb begin
    carry_s    = 9'd0;
    carry_s[0] = cin;
    for (int i = 0; i < 8; i++) begin
      carry_s[i+1] = gen_s[i] | (prop_s[i] & carry_s[i]);
    end
  end

  assign sum  = prop_s ^ carry_s[7:0];
  assign cout = carry_s[8];

endmodule

// File: rtl/cla_seq_wide_adder.sv
// Multi-cycle (8*NBYTES)-bit adder that drives one carry_lookahead_adder_8bit slice per cycle.
// Optional macro OVF_FLAG_EN adds the result_ovf signed-overflow output.
module cla_seq_wide_adder
  import cla_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*NBYTES-1:0]     op_a,
  input  logic [8*NBYTES-1:0]     op_b,
  input  logic                    op_cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*NBYTES-1:0]     result,
  output logic                    result_cout
`ifdef OVF_FLAG_EN
  ,
  output logic                    result_ovf
`endif
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic            carry_r;
  logic [W-1:0]    op_a_r;
  logic [W-1:0]    op_b_r;
  logic [W-1:0]    result_r;
  logic            cout_r;
  logic            in_ready_r;
  logic            out_valid_r;
`ifdef OVF_FLAG_EN
  logic            ovf_r;
`endif

  logic [BYTE_W-1:0] slice_a_s;
  logic [BYTE_W-1:0] slice_b_s;
  logic [BYTE_W-1:0] slice_sum_s;
  logic              slice_cout_s;
  logic              last_s;

  assign slice_a_s = op_a_r[BYTE_W*int'(idx_r) +: BYTE_W];
  assign slice_b_s = op_b_r[BYTE_W*int'(idx_r) +: BYTE_W];
  assign last_s    = (idx_r == LAST_IDX);

  carry_lookahead_adder_8bit u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // FSM, operand capture and per-slice accumulation; handshake flags are registered state decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      result_r    <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_a_r     <= op_a;
            op_b_r     <= op_b;
            carry_r    <= op_cin;
            idx_r      <= '0;
            state_r    <= ADD;
            in_ready_r <= 1'b0;
          end
        end
        ADD: begin
          result_r[BYTE_W*int'(idx_r) +: BYTE_W] <= slice_sum_s;
          carry_r <= slice_cout_s;
          if (last_s) begin
            // Index wraps to 0 rather than stepping past the top slice.
            idx_r       <= '0;
            cout_r      <= slice_cout_s;
            state_r     <= DONE;
            out_valid_r <= 1'b1;
`ifdef OVF_FLAG_EN
            ovf_r <= (slice_a_s[BYTE_W-1] == slice_b_s[BYTE_W-1]) &&
                     (slice_sum_s[BYTE_W-1] != slice_a_s[BYTE_W-1]);
`endif
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign result      = result_r;
  assign result_cout = cout_r;
`ifdef OVF_FLAG_EN
  assign result_ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_cla_seq_wide_adder.sv
// Directed self-checking bench for cla_seq_wide_adder (NBYTES=4 main instance, NBYTES=1 side instance).
module tb_cla_seq_wide_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        result_cout;

  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  op_a1;
  logic [7:0]  op_b1;
  logic        op_cin1;
  logic        out_valid1;
  logic        out_ready1;
  logic [7:0]  result1;
  logic        result_cout1;
`ifdef OVF_FLAG_EN
  logic        result_ovf;
  logic        result_ovf1;
`endif

  int checks;
  int errors;

  cla_seq_wide_adder #(.NBYTES(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_cout (result_cout)
`ifdef OVF_FLAG_EN
    ,
    .result_ovf  (result_ovf)
`endif
  );

  cla_seq_wide_adder #(.NBYTES(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid1),
    .in_ready    (in_ready1),
    .op_a        (op_a1),
    .op_b        (op_b1),
    .op_cin      (op_cin1),
    .out_valid   (out_valid1),
    .out_ready   (out_ready1),
    .result      (result1),
    .result_cout (result_cout1)
`ifdef OVF_FLAG_EN
    ,
    .result_ovf  (result_ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(negedge clk);
    op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (result_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", result_cout); end
`ifdef OVF_FLAG_EN
    checks++; if (result_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", result_ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_carry();
    int cyc;
    start_op(32'h000000FF, 32'h00000001, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_busy: got %b expected 0", in_ready); end
    wait_done(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", cyc); end
    checks++; if (result !== 32'h00000100) begin errors++; $display("FAIL basic_result: got %h expected 00000100", result); end
    checks++; if (result_cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", result_cout); end
    finish_op();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_full_ripple();
    int cyc;
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_done(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL ripple_latency: got %0d expected 4", cyc); end
    checks++; if (result !== 32'h00000000) begin errors++; $display("FAIL ripple_result: got %h expected 00000000", result); end
    checks++; if (result_cout !== 1'b1) begin errors++; $display("FAIL ripple_cout: got %b expected 1", result_cout); end
`ifdef OVF_FLAG_EN
    checks++; if (result_ovf !== 1'b0) begin errors++; $display("FAIL ripple_ovf: got %b expected 0", result_ovf); end
`endif
    finish_op();
  endtask

  task automatic test_carry_in_chain();
    int cyc;
    start_op(32'hAAAAAAAA, 32'h55555555, 1'b1);
    wait_done(cyc);
    checks++; if (result !== 32'h00000000) begin errors++; $display("FAIL cin_chain1_result: got %h expected 00000000", result); end
    checks++; if (result_cout !== 1'b1) begin errors++; $display("FAIL cin_chain1_cout: got %b expected 1", result_cout); end
    finish_op();
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done(cyc);
    checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL cin_chain2_result: got %h expected FFFFFFFF", result); end
    checks++; if (result_cout !== 1'b1) begin errors++; $display("FAIL cin_chain2_cout: got %b expected 1", result_cout); end
    finish_op();
    // Mixed-byte vector: 0x12345678 + 0x9ABCDEF0 + 1 = 0xACF13569, no carry-out.
    start_op(32'h12345678, 32'h9ABCDEF0, 1'b1);
    wait_done(cyc);
    checks++; if (result !== 32'hACF13569) begin errors++; $display("FAIL mixed_result: got %h expected ACF13569", result); end
    checks++; if (result_cout !== 1'b0) begin errors++; $display("FAIL mixed_cout: got %b expected 0", result_cout); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int cyc;
    start_op(32'h12345678, 32'h11111111, 1'b0);
    // Operand changes after acceptance must not leak in.
    op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    wait_done(cyc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op_a = 32'h00000001 + i; op_b = 32'h00000002;
      @(posedge clk); #1;
      checks++; if (result !== 32'h23456789 || result_cout !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got %h/%b expected 23456789/0", i, result, result_cout); end
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_flags_%0d: got out_valid=%b in_ready=%b expected 1/0", i, out_valid, in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_op();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    repeat (2) @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_pulses: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    start_op(32'h00000010, 32'h00000020, 1'b0);
    wait_done(cyc);
    checks++; if (result !== 32'h00000030) begin errors++; $display("FAIL bp_next_result: got %h expected 00000030", result); end
    finish_op();
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_async: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result_clear: got %h expected 00000000", result); end
    start_op(32'h00000003, 32'h00000004, 1'b0);
    wait_done(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL midrst_latency: got %0d expected 4", cyc); end
    checks++; if (result !== 32'h00000007 || result_cout !== 1'b0) begin errors++; $display("FAIL midrst_next_add: got %h/%b expected 00000007/0", result, result_cout); end
    finish_op();
  endtask

  task automatic test_overflow();
`ifdef OVF_FLAG_EN
    int cyc;
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_done(cyc);
    checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL ovf_pos_result: got %h expected 80000000", result); end
    checks++; if (result_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos_flag: got %b expected 1", result_ovf); end
    repeat (2) @(posedge clk); #1;
    checks++; if (result_ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", result_ovf); end
    finish_op();
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_done(cyc);
    checks++; if (result_ovf !== 1'b0) begin errors++; $display("FAIL ovf_wrap_flag: got %b expected 0", result_ovf); end
    finish_op();
`endif
  endtask

  task automatic test_nbytes1();
    int cyc;
    logic [8:0] exp_v [2];
    logic [7:0] a_v [2];
    logic [7:0] b_v [2];
    a_v[0] = 8'hFF; b_v[0] = 8'h01; exp_v[0] = 9'h100;
    a_v[1] = 8'h7F; b_v[1] = 8'h01; exp_v[1] = 9'h080;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      op_a1 = a_v[k]; op_b1 = b_v[k]; op_cin1 = 1'b0; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      cyc = 0;
      while (!out_valid1 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      checks++; if (cyc !== 1) begin errors++; $display("FAIL n1_latency_%0d: got %0d expected 1", k, cyc); end
      checks++; if ({result_cout1, result1} !== exp_v[k]) begin errors++; $display("FAIL n1_sum_%0d: got %h expected %h", k, {result_cout1, result1}, exp_v[k]); end
`ifdef OVF_FLAG_EN
      checks++; if (result_ovf1 !== (k == 1)) begin errors++; $display("FAIL n1_ovf_%0d: got %b expected %b", k, result_ovf1, (k == 1)); end
`endif
      @(negedge clk);
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL n1_release_%0d: got %b expected 1", k, in_ready1); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    in_valid = 1'b0; out_ready = 1'b0; op_a = 32'h0; op_b = 32'h0; op_cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; op_a1 = 8'h0; op_b1 = 8'h0; op_cin1 = 1'b0;
    test_reset();
    test_basic_carry();
    test_full_ripple();
    test_carry_in_chain();
    test_backpressure();
    test_reset_mid_op();
    test_overflow();
    test_nbytes1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
